// File: rtl/ps_filter_pkg.sv
// Shared encodings and defaults for the filter-chain mode sequencer.
package ps_filter_pkg;

  // Filter mode encoding: bit 0 enables Gaussian, bit 1 enables Sobel.
  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_GAUS   = 2'd1;
  localparam logic [1:0] MODE_SOBEL  = 2'd2;
  localparam logic [1:0] MODE_BOTH   = 2'd3;

  // Default frame geometry and flush length.
  localparam int DEF_LINE_W       = 640;
  localparam int DEF_FRAME_H      = 480;
  localparam int DEF_FLUSH_CYCLES = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ps_pixel_counter.sv
// Column/row position tracker driven by the filter chain's pixel strobe.
module ps_pixel_counter
  import ps_filter_pkg::*;
#(
  parameter int LINE_W  = DEF_LINE_W,
  parameter int FRAME_H = DEF_FRAME_H
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,      // hold both counters at the origin
  input  logic i_adv,        // one pixel emitted this cycle
  input  logic i_sof,        // this pixel is the first of a frame
  output logic o_frame_end,  // this pixel is the last of a frame
  output logic o_at_origin   // counters currently at (0,0)
);

  localparam int CW = cnt_w(LINE_W);
  localparam int RW = cnt_w(FRAME_H);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_H - 1);

  logic [CW-1:0] col_q, col_d, col_base;
  logic [RW-1:0] row_q, row_d, row_base;

  // Next position: a SOF pixel is treated as (0,0), so advance from the origin.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    col_base = i_sof ? '0 : col_q;
    row_base = i_sof ? '0 : row_q;
    if (i_clear) begin
      col_d = '0;
      row_d = '0;
    end else if (i_adv) begin
      if (col_base == COL_LAST) begin
        col_d = '0;
        row_d = (row_base == ROW_LAST) ? '0 : row_base + 1'b1;
      end else begin
        col_d = col_base + 1'b1;
        row_d = row_base;
      end
    end
  end

  assign o_frame_end = i_adv && !i_clear && !i_sof &&
                       (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign o_at_origin = (col_q == '0) && (row_q == '0);

  // Position registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/ps_filter_ctrl.sv
// Mode sequencer: latches mode requests and applies them only at frame
// boundaries, followed by a fixed-length flush of the filter pipeline.
module ps_filter_ctrl
  import ps_filter_pkg::*;
#(
  parameter int LINE_W       = DEF_LINE_W,
  parameter int FRAME_H      = DEF_FRAME_H,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_mode_req,
  input  logic       i_mode_req_valid,
  input  logic       i_pix_valid,
  input  logic       i_sof,
  output logic       o_gaus_en,
  output logic       o_sobel_en,
  output logic       o_flush,
  output logic [1:0] o_mode,
  output logic       o_pending,
  output logic       o_frame_done,
  output logic       o_sync_err
);

  localparam int FW = cnt_w(FLUSH_CYCLES);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    pend_q, pend_d;        // mode waiting for the next frame end
  logic [1:0]    fl_req_q, fl_req_d;    // request captured while flushing
  logic          fl_vld_q, fl_vld_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic          pending_q, pending_d;
  logic          flush_q, flush_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          gaus_q, gaus_d;
  logic          sobel_q, sobel_d;

  logic          frame_end;
  logic          at_origin;
  logic          in_flush;

  assign in_flush = (state_q == ST_FLUSH);

  ps_pixel_counter #(
    .LINE_W  (LINE_W),
    .FRAME_H (FRAME_H)
  ) u_counter (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (in_flush),
    .i_adv       (i_pix_valid),
    .i_sof       (i_sof),
    .o_frame_end (frame_end),
    .o_at_origin (at_origin)
  );

  // Sequencer next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pend_d      = pend_q;
    fl_req_d    = fl_req_q;
    fl_vld_d    = fl_vld_q;
    flush_cnt_d = flush_cnt_q;
    done_d      = frame_end;
    err_d       = err_q | (i_pix_valid && i_sof && !in_flush && !at_origin);

    case (state_q)
      ST_RUN: begin
        if (i_mode_req_valid && (i_mode_req != mode_q)) begin
          pend_d  = i_mode_req;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (i_mode_req_valid) begin
          if (i_mode_req == mode_q) state_d = ST_RUN;
          else                      pend_d  = i_mode_req;
        end
        if (frame_end && (state_d == ST_PEND)) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
          fl_vld_d    = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (i_mode_req_valid) begin
          fl_vld_d = 1'b1;
          fl_req_d = i_mode_req;
        end
        if (flush_cnt_q == FLUSH_LAST) begin
          mode_d  = pend_q;
          state_d = ST_RUN;
          // A request seen during the flush becomes the next pending change.
          if (fl_vld_d && (fl_req_d != pend_q)) begin
            pend_d  = fl_req_d;
            state_d = ST_PEND;
          end
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    pending_d = (state_d != ST_RUN);
    flush_d   = (state_d == ST_FLUSH);
    gaus_d    = mode_d[0];
    sobel_d   = mode_d[1];
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_RUN;
      mode_q      <= MODE_BYPASS;
      pend_q      <= MODE_BYPASS;
      fl_req_q    <= MODE_BYPASS;
      fl_vld_q    <= 1'b0;
      flush_cnt_q <= '0;
      pending_q   <= 1'b0;
      flush_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      gaus_q      <= 1'b0;
      sobel_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      fl_req_q    <= fl_req_d;
      fl_vld_q    <= fl_vld_d;
      flush_cnt_q <= flush_cnt_d;
      pending_q   <= pending_d;
      flush_q     <= flush_d;
      done_q      <= done_d;
      err_q       <= err_d;
      gaus_q      <= gaus_d;
      sobel_q     <= sobel_d;
    end
  end

  assign o_mode       = mode_q;
  assign o_pending    = pending_q;
  assign o_flush      = flush_q;
  assign o_frame_done = done_q;
  assign o_sync_err   = err_q;
  assign o_gaus_en    = gaus_q;
  assign o_sobel_en   = sobel_q;

endmodule

// File: doc/ps_filter_ctrl.md
# ps_filter_ctrl

Mode sequencer for the video filter chain (passthrough, Gaussian, Sobel, Gaussian+Sobel). Accepts asynchronous mode-change requests and tracks pixel/line position from the chain's output valid strobe. Applies any pending mode only at a frame boundary, then asserts a timed flush to the line buffers and kernels so no frame mixes two filter settings. Sits between the user-control logic and the filter tops, driving their enable and flush inputs.

## Interface
- LINE_W, 640, pixels per line
- FRAME_H, 480, lines per frame
- FLUSH_CYCLES, 4, flush pulse length in clocks (≥1)
- i_clk  in  1  pixel-domain clock
- i_rst  in  1  reset; one clock; reset is synchronous and active-high
- i_mode_req  in  2  requested mode (0 bypass, 1 gaussian, 2 sobel, 3 gaussian+sobel)
- i_mode_req_valid  in  1  single-cycle strobe qualifying i_mode_req
- i_pix_valid  in  1  one pixel emitted by the filter chain this cycle
- i_sof  in  1  start-of-frame marker, meaningful only with i_pix_valid
- o_gaus_en  out  1  Gaussian stage enable
- o_sobel_en  out  1  Sobel stage enable
- o_flush  out  1  flush to line buffers/kernels
- o_mode  out  2  currently applied mode
- o_pending  out  1  a change is latched, awaiting frame end
- o_frame_done  out  1  one-cycle pulse after the last pixel of each frame
- o_sync_err  out  1  sticky: i_sof arrived off a frame boundary

## Operation
- States: RUN, PEND, FLUSH. Reset: RUN, o_mode=0, all other outputs 0, counters 0, pending register 0.
- Column counter 0..LINE_W-1 and row counter 0..FRAME_H-1 advance on i_pix_valid outside FLUSH; column wraps to 0 and increments row; row wraps at FRAME_H-1. Widths $clog2(LINE_W), $clog2(FRAME_H).
- Frame end: i_pix_valid with col=LINE_W-1, row=FRAME_H-1.
- RUN: request with value ≠ o_mode latches pending, goes to PEND; request equal to o_mode is ignored.
- PEND: new request overwrites the pending value (last wins). A request equal to o_mode cancels and returns to RUN. On frame end, goes to FLUSH.
- FLUSH: o_flush=1 for exactly FLUSH_CYCLES clocks. Counters held at 0. i_pix_valid ignored. On exit: o_mode←pending, enables updated, state RUN, o_pending=0. A request during FLUSH is latched and gives PEND on exit if it differs from the newly applied mode.
- Frame end in RUN raises o_frame_done only; no flush.
- i_sof with i_pix_valid: the pixel counts as (0,0), so counters become col=1,row=0. If the counters were not at (0,0) beforehand, set o_sync_err. Frame end is not inferred from i_sof.
- o_gaus_en = mode[0], o_sobel_en = mode[1], both registered from o_mode.

## Timing
- All outputs registered.
- Request at cycle t → o_pending=1 at t+1.
- Frame-end pixel at cycle t (state PEND) → o_frame_done=1 and o_flush=1 at t+1. o_flush stays high through t+FLUSH_CYCLES. New o_mode and enables take effect at t+FLUSH_CYCLES+1, with o_flush=0 and o_pending=0 in that cycle.
- Request in the same cycle as the frame-end pixel while in PEND: the request overwrites the pending value before it is applied.
- Request in the same cycle as the frame-end pixel while in RUN: latched to PEND. Flush happens at the next frame end.
- i_rst mid-FLUSH: o_flush drops on the next clock, o_mode=0, pending discarded.

## Structure
- Package ps_filter_pkg holds:
  - mode encoding localparams: MODE_BYPASS, MODE_GAUS, MODE_SOBEL, MODE_BOTH
  - state encodings
  - default LINE_W/FRAME_H
- Sub-module ps_pixel_counter: parameterised col/row counter with hold, clear and SOF load. It outputs a frame-end strobe and an at-origin flag.

## Test plan
- Reset, then 640×480 pixels with no request → o_mode=0, one o_frame_done at the cycle after pixel 307199, o_flush never asserted.
- Request 1 at pixel 1000 → o_pending=1 next cycle. Flush high exactly 4 cycles after the frame end. o_gaus_en=1 and o_mode=1 on the 5th cycle after frame end.
- Requests 1, then 2, then 0 within one frame, starting from mode 0 → the third request cancels, o_pending=0, no flush at frame end.
- Request 3 coincident with the frame-end pixel while in PEND(1) → mode 3 applied after the flush. In RUN instead → mode 3 applied one frame later.
- i_sof at col=100,row=5 → counters become (1,0), o_sync_err=1 and stays set. A later clean frame leaves it set until i_rst.
- i_rst asserted during the 2nd flush cycle → o_flush=0, o_mode=0 next cycle. No pixels counted while reset is held.
